// File: rtl/instr_fetch_unit.sv
// Program counter and instruction fetch stage: fetches over req/ack,
// hands instructions to decode over valid/ready, and selects the next PC.
module instr_fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 Reset,
    output logic                 InstrReq,
    output logic [63:0]          InstrAddr,
    input  logic                 InstrAck,
    input  logic [31:0]          InstrData,
    output logic                 InstrValid,
    output logic [31:0]          Instr32,
    output logic [63:0]          CurPC,
    input  logic                 DecodeReady,
    input  logic                 Branch,
    input  logic                 Uncondbranch,
    input  logic                 Zero,
    input  logic [63:0]          BusImm,
    output logic [CNT_WIDTH-1:0] RetireCount
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD
    } state_t;

    state_t      state;
    logic [63:0] pc;
    logic        taken;
    logic [63:0] offset;
    logic [63:0] next_pc;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Branch targets are word offsets relative to the held instruction.
    always_comb begin
        taken   = Uncondbranch | (Branch & Zero);
        offset  = taken ? (BusImm << 2) : 64'd4;
        next_pc = CurPC + offset;
    end

    assign InstrAddr = pc;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            InstrReq    <= 1'b0;
            InstrValid  <= 1'b0;
            Instr32     <= 32'h0;
            CurPC       <= RESET_PC;
            RetireCount <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    state    <= S_REQ;
                    InstrReq <= 1'b1;
                end
                S_REQ: begin
                    if (InstrAck) begin
                        Instr32    <= InstrData;
                        CurPC      <= pc;
                        InstrReq   <= 1'b0;
                        InstrValid <= 1'b1;
                        state      <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (DecodeReady) begin
                        RetireCount <= RetireCount + CNT_ONE;
                        pc          <= next_pc;
                        InstrValid  <= 1'b0;
                        InstrReq    <= 1'b1;
                        state       <= S_REQ;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    InstrReq   <= 1'b0;
                    InstrValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed fetch/branch/stall/reset
// vectors with hand-computed addresses checked by a negedge monitor.
module tb_instr_fetch_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        InstrReq;
    logic [63:0] InstrAddr;
    logic        InstrAck;
    logic [31:0] InstrData;
    logic        InstrValid;
    logic [31:0] Instr32;
    logic [63:0] CurPC;
    logic        DecodeReady;
    logic        Branch;
    logic        Uncondbranch;
    logic        Zero;
    logic [63:0] BusImm;
    logic [3:0]  RetireCount;

    instr_fetch_unit #(
        .RESET_PC (64'h100),
        .CNT_WIDTH(4)
    ) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .InstrReq    (InstrReq),
        .InstrAddr   (InstrAddr),
        .InstrAck    (InstrAck),
        .InstrData   (InstrData),
        .InstrValid  (InstrValid),
        .Instr32     (Instr32),
        .CurPC       (CurPC),
        .DecodeReady (DecodeReady),
        .Branch      (Branch),
        .Uncondbranch(Uncondbranch),
        .Zero        (Zero),
        .BusImm      (BusImm),
        .RetireCount (RetireCount)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int passed = 0;

    logic [63:0] addr_q[$];
    logic [63:0] acc_q[$];
    logic [3:0]  exp_ret = 4'd0;
    logic        prev_ack = 1'b0;
    logic        prev_acc = 1'b0;

    function automatic logic [31:0] mem(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: compares DUT outputs against the queued expectations.
    always @(negedge CLK) begin
        if (Reset) begin
            exp_ret  = 4'd0;
            prev_ack = 1'b0;
            prev_acc = 1'b0;
        end else begin
            if (prev_ack) chk("valid_after_ack", {63'd0, InstrValid}, 64'd1);
            if (prev_acc) chk("req_after_ready", {63'd0, InstrReq}, 64'd1);
            prev_ack = InstrReq && InstrAck;
            prev_acc = InstrValid && DecodeReady;
            if (InstrReq && addr_q.size() > 0) begin
                chk("req_addr", InstrAddr, addr_q[0]);
                chk("no_valid_in_req", {63'd0, InstrValid}, 64'd0);
                if (InstrAck) void'(addr_q.pop_front());
            end
            if (InstrValid && acc_q.size() > 0) begin
                chk("cur_pc", CurPC, acc_q[0]);
                chk("instr32", {32'd0, Instr32}, {32'd0, mem(acc_q[0])});
                chk("no_req_in_hold", {63'd0, InstrReq}, 64'd0);
                if (DecodeReady) begin
                    chk("retire", {60'd0, RetireCount}, {60'd0, exp_ret});
                    exp_ret = exp_ret + 4'd1;
                    void'(acc_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_instr(input int ack_dly, input int rdy_dly,
                            input logic br, input logic ub, input logic z,
                            input logic [63:0] imm, input logic [63:0] exp_addr);
        int n;
        addr_q.push_back(exp_addr);
        acc_q.push_back(exp_addr);
        n = 0;
        while (!InstrReq && n < 20) begin
            step();
            n++;
        end
        if (!InstrReq) chk("req_timeout", 64'd0, 64'd1);
        repeat (ack_dly) step();
        InstrData = mem(InstrAddr);
        InstrAck  = 1'b1;
        step();
        InstrAck  = 1'b0;
        InstrData = 32'hDEAD_BEEF;
        repeat (rdy_dly) step();
        DecodeReady  = 1'b1;
        Branch       = br;
        Uncondbranch = ub;
        Zero         = z;
        BusImm       = imm;
        step();
        DecodeReady  = 1'b0;
        Branch       = 1'b0;
        Uncondbranch = 1'b0;
        Zero         = 1'b0;
        BusImm       = 64'h0BAD_0BAD_0BAD_0BAD;
    endtask

    task automatic chk_reset_state();
        chk("rst_req", {63'd0, InstrReq}, 64'd0);
        chk("rst_valid", {63'd0, InstrValid}, 64'd0);
        chk("rst_instr", {32'd0, Instr32}, 64'd0);
        chk("rst_curpc", CurPC, 64'h100);
        chk("rst_retire", {60'd0, RetireCount}, 64'd0);
        chk("rst_addr", InstrAddr, 64'h100);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        InstrAck = 1'b0;
        InstrData = 32'hDEAD_BEEF;
        DecodeReady = 1'b0;
        Branch = 1'b0;
        Uncondbranch = 1'b0;
        Zero = 1'b0;
        BusImm = 64'h0;
        step();
        step();
        Reset = 1'b0;
        chk_reset_state();

        // Sequential fetch; 18 retirements wrap the 4-bit counter.
        for (int i = 0; i < 18; i++)
            do_instr(0, 0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h100 + 64'(4 * i));
        // Late ack, then decode stall.
        do_instr(3, 0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h148);
        do_instr(0, 5, 1'b0, 1'b0, 1'b0, 64'h0, 64'h14C);
        // Branch cases.
        do_instr(0, 0, 1'b0, 1'b1, 1'b0, 64'h2C, 64'h150);
        do_instr(0, 0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h200);
        do_instr(0, 0, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1F0);
        do_instr(0, 0, 1'b0, 1'b1, 1'b0, 64'h3, 64'h1F4);
        do_instr(0, 0, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h200);
        do_instr(0, 0, 1'b1, 1'b0, 1'b1, 64'h2, 64'h204);
        do_instr(0, 0, 1'b1, 1'b1, 1'b0, 64'h1, 64'h20C);
        // Jump to the top of the address space, then wrap to zero.
        do_instr(0, 0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF7B, 64'h210);
        do_instr(0, 0, 1'b0, 1'b0, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC);
        do_instr(1, 0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);

        // Reset while a request to 0x4 is outstanding; ack arrives late.
        step();
        chk("req_pending", {63'd0, InstrReq}, 64'd1);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk_reset_state();
        InstrData = 32'h1234_5678;
        InstrAck = 1'b1;
        step();
        InstrAck = 1'b0;
        InstrData = 32'hDEAD_BEEF;
        chk("late_ack_valid", {63'd0, InstrValid}, 64'd0);
        chk("late_ack_instr", {32'd0, Instr32}, 64'd0);
        do_instr(0, 0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h100);
        do_instr(2, 1, 1'b0, 1'b0, 1'b0, 64'h0, 64'h104);

        step();
        chk("addr_q_empty", 64'(addr_q.size()), 64'd0);
        chk("acc_q_empty", 64'(acc_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
